// File: rtl/data_sram_responder.sv
// data_sram_responder: word-addressed data store answering req/addr_ok requests with fixed-latency in-order data_ok completions.
module data_sram_responder #(
  parameter int AW      = 10,
  parameter int LATENCY = 2,
  parameter int MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);
  logic [31:0]   mem_q [2**AW];
  logic [31:0]   dat_q [4];
  logic [31:0]   dat_d [4];
  logic [2:0]    cd_q [4];
  logic [2:0]    cd_d [4];
  logic [1:0]    rd_q, rd_d, wp_q, wp_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          acc, aligned, unused;
  logic [AW-1:0] idx;
  assign idx     = addr[AW+1:2];
  assign unused  = ^addr[31:AW+2];
  assign aligned = size == 2'd0 || (size == 2'd1 && !addr[0]) || (size == 2'd2 && addr[1:0] == 2'b00);
  assign data_ok = cnt_q != 3'd0 && cd_q[rd_q] == 3'd0;
  assign addr_ok = cnt_q < 3'(MAX_OUT) || data_ok;
  assign acc     = req && addr_ok;
  assign rdata   = data_ok ? dat_q[rd_q] : rdata_q;
  // Queue slots beyond MAX_OUT exist only to keep the pointer width fixed; they are never addressed.
  always_comb begin
    dat_d = dat_q;
    for (int i = 0; i < 4; i++) cd_d[i] = cd_q[i] == 3'd0 ? 3'd0 : cd_q[i] - 3'd1;
    rd_d    = data_ok ? (rd_q == 2'(MAX_OUT-1) ? 2'd0 : rd_q + 2'd1) : rd_q;
    wp_d    = acc ? (wp_q == 2'(MAX_OUT-1) ? 2'd0 : wp_q + 2'd1) : wp_q;
    cnt_d   = cnt_q + 3'(acc) - 3'(data_ok);
    rdata_d = data_ok ? dat_q[rd_q] : rdata_q;
    if (acc) begin
      dat_d[wp_q] = (wr || !aligned) ? 32'd0 : mem_q[idx];
      cd_d[wp_q]  = 3'(LATENCY-1);
    end
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      for (int i = 0; i < 4; i++) begin
        dat_q[i] <= 32'd0;
        cd_q[i]  <= 3'd0;
      end
      rd_q    <= 2'd0;
      wp_q    <= 2'd0;
      cnt_q   <= 3'd0;
      rdata_q <= 32'd0;
    end else begin
      dat_q   <= dat_d;
      cd_q    <= cd_d;
      rd_q    <= rd_d;
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  // Memory contents survive reset; writes are blocked only while reset is held.
  always_ff @(posedge clk)
    if (resetn && acc && wr && aligned)
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
endmodule
